mc_control_fsm: RTL and testbench
=================================

Name: mc_control_fsm

Overview:
- Multicycle control unit for the 32-bit MIPS-subset datapath.
- Sequences each instruction through fetch, decode, execute, memory and writeback.
- Drives every datapath select and write enable, including the ALU A-source and B-source mux selects.
- Handles memory wait cycles with a counter, and routes arithmetic overflow and illegal opcodes to an exception state.

Parameters:
- MEM_LATENCY, 2, cycles from presenting a memory address until read data is valid (1..7).
- EXC_VECTOR_SEL, 2'b11, pc_source value that selects the exception-handler address.

Ports:
- clk  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- opcode  input  6  instruction bits [31:26] from the IR.
- funct  input  6  instruction bits [5:0] from the IR.
- zero  input  1  ALU zero flag.
- overflow  input  1  ALU overflow flag.
- alu_src_a  output  1  0=PC, 1=register A.
- alu_src_b  output  2  00=B, 01=constant 4, 10/11=sign-extended immediate.
- alu_op  output  3  001=add, 010=sub, 011=and; 000 when idle.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if zero=1.
- pc_source  output  2  00=ALU result, 01=ALUOut, 10=jump target, 11=exception vector.
- iord  output  1  memory address select: 0=PC, 1=ALUOut.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  instruction register load.
- ab_load  output  1  load A/B from the register file.
- aluout_write  output  1  load ALUOut.
- mdr_write  output  1  load the memory data register.
- reg_write  output  1  register file write.
- reg_dst  output  1  0=rt, 1=rd.
- mem_to_reg  output  1  0=ALUOut, 1=MDR.
- epc_write  output  1  load EPC with the ALU result (PC-4).
- state_o  output  4  current state code, for debug.

Behaviour:
- Moore machine: every output is decoded from the state register only. Outputs not listed for a state are 0.
- A 3-bit wait counter is cleared on every state transition.
- Reset: reset=1 at a clock edge forces the RST state and clears the counter, including mid-instruction.
  - In RST all outputs are 0; no write occurs in the reset cycle or the cycle after.
  - RST is followed by FETCH.
- FETCH:
  - iord=0; alu_src_a=0; alu_src_b=01; alu_op=001.
  - The counter increments each cycle. While counter<MEM_LATENCY, no writes are issued.
  - When counter==MEM_LATENCY: ir_write=1, pc_write=1, pc_source=00; next state is DECODE.
  - FETCH therefore occupies MEM_LATENCY+1 cycles.
- DECODE (1 cycle): alu_src_a=0, alu_src_b=11, alu_op=001, ab_load=1, aluout_write=1. Dispatch on opcode:
  - 0x00 R-type: funct 0x20/0x22/0x24 go to EXEC_R; any other funct goes to EXC.
  - 0x08 goes to EXEC_I.
  - 0x23 or 0x2B goes to ADDR.
  - 0x04 goes to BRANCH.
  - 0x02 goes to JUMP.
  - Any other opcode goes to EXC.
- EXEC_R:
  - alu_src_a=1, alu_src_b=00, aluout_write=1.
  - alu_op: 001 for funct 0x20, 010 for 0x22, 011 for 0x24.
  - If overflow=1 and funct is 0x20 or 0x22, go to EXC; otherwise go to WB_R.
- WB_R: reg_write=1, reg_dst=1, mem_to_reg=0; then FETCH.
- EXEC_I:
  - alu_src_a=1, alu_src_b=10, alu_op=001, aluout_write=1.
  - overflow=1 goes to EXC; otherwise go to WB_I.
- WB_I: reg_write=1, reg_dst=0, mem_to_reg=0; then FETCH.
- ADDR: alu_src_a=1, alu_src_b=10, alu_op=001, aluout_write=1. Opcode 0x23 goes to MEM_RD; 0x2B goes to MEM_WR.
- MEM_RD:
  - iord=1; the counter waits as in FETCH.
  - At counter==MEM_LATENCY: mdr_write=1; then WB_L.
- WB_L: reg_write=1, reg_dst=0, mem_to_reg=1; then FETCH.
- MEM_WR: iord=1, mem_write=1 for exactly one cycle; then FETCH. The write takes effect at that edge; no wait is needed.
- BRANCH: alu_src_a=1, alu_src_b=00, alu_op=010, pc_write_cond=1, pc_source=01; then FETCH.
- JUMP: pc_write=1, pc_source=10; then FETCH.
- EXC (two cycles, counter 0 then 1):
  - Cycle 0: alu_src_a=0, alu_src_b=01, alu_op=010, epc_write=1.
  - Cycle 1: pc_write=1, pc_source=EXC_VECTOR_SEL.
  - Then FETCH.
- Overflow during WB_*, FETCH or DECODE is ignored.
- alu_src_b value 11 is emitted only in DECODE. The value 10 is used everywhere else an immediate is needed.
- State codes for state_o: RST=0, FETCH=1, DECODE=2, EXEC_R=3, WB_R=4, EXEC_I=5, WB_I=6, ADDR=7, MEM_RD=8, WB_L=9, MEM_WR=10, BRANCH=11, JUMP=12, EXC=13.

Test Plan:
- Reset, then add (opcode 0x00, funct 0x20), overflow=0, MEM_LATENCY=2 -> state_o sequence 0,1,1,1,2,3,4,1; alu_src_b 01,01,01,11,00,00.
  - ir_write and pc_write high only on the third FETCH cycle; reg_write high only in WB_R with reg_dst=1.
- lw (opcode 0x23) -> ADDR has alu_src_b=10; MEM_RD lasts 3 cycles with iord=1; mdr_write on the last cycle only; WB_L has mem_to_reg=1, reg_dst=0.
  - Total 9 cycles from FETCH entry to the next FETCH.
- sw (opcode 0x2B) -> mem_write=1 for exactly one cycle, iord=1; reg_write stays 0 throughout.
- beq (opcode 0x04) with zero=1 and with zero=0 -> BRANCH shows pc_write_cond=1, pc_source=01, alu_op=010 in both cases; pc_write=0.
- addi (opcode 0x08) with overflow=1 in EXEC_I -> next states EXC, EXC, FETCH.
  - EXC cycle 0 has epc_write=1; cycle 1 has pc_write=1, pc_source=11; reg_write never asserted.
  - Also: opcode 0x3F -> DECODE then EXC.
- reset=1 asserted during MEM_RD counter=1 -> next state RST with all outputs 0; no mdr_write or reg_write; FETCH on the following cycle with the counter restarting at 0.

Source files
------------

// File: rtl/mc_control_fsm.sv
// Multicycle control unit for the 32-bit MIPS-subset datapath.
// Sequences fetch/decode/execute/memory/writeback and drives all datapath
// selects and write enables. Outputs are decoded from the state register and
// the wait counter only; the IR fields steer transitions and the R-type ALU op.
module mc_control_fsm #(
  parameter int unsigned MEM_LATENCY    = 2,
  parameter logic [1:0]  EXC_VECTOR_SEL = 2'b11
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] opcode,
  input  logic [5:0] funct,
  input  logic       zero,
  input  logic       overflow,
  output logic       alu_src_a,
  output logic [1:0] alu_src_b,
  output logic [2:0] alu_op,
  output logic       pc_write,
  output logic       pc_write_cond,
  output logic [1:0] pc_source,
  output logic       iord,
  output logic       mem_write,
  output logic       ir_write,
  output logic       ab_load,
  output logic       aluout_write,
  output logic       mdr_write,
  output logic       reg_write,
  output logic       reg_dst,
  output logic       mem_to_reg,
  output logic       epc_write,
  output logic [3:0] state_o
);

  typedef enum logic [3:0] {
    StRst    = 4'd0,
    StFetch  = 4'd1,
    StDecode = 4'd2,
    StExecR  = 4'd3,
    StWbR    = 4'd4,
    StExecI  = 4'd5,
    StWbI    = 4'd6,
    StAddr   = 4'd7,
    StMemRd  = 4'd8,
    StWbL    = 4'd9,
    StMemWr  = 4'd10,
    StBranch = 4'd11,
    StJump   = 4'd12,
    StExc    = 4'd13
  } state_e;

  localparam logic [5:0] OpRtype = 6'h00;
  localparam logic [5:0] OpAddi  = 6'h08;
  localparam logic [5:0] OpLw    = 6'h23;
  localparam logic [5:0] OpSw    = 6'h2B;
  localparam logic [5:0] OpBeq   = 6'h04;
  localparam logic [5:0] OpJ     = 6'h02;

  localparam logic [5:0] FnAdd = 6'h20;
  localparam logic [5:0] FnSub = 6'h22;
  localparam logic [5:0] FnAnd = 6'h24;

  localparam logic [2:0] AluIdle = 3'b000;
  localparam logic [2:0] AluAdd  = 3'b001;
  localparam logic [2:0] AluSub  = 3'b010;
  localparam logic [2:0] AluAnd  = 3'b011;

  localparam logic [2:0] LastWait = 3'(MEM_LATENCY);

  state_e     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;
  logic       mem_done;

  // Memory access completes once the counter has reached the latency.
  assign mem_done = (cnt_q == LastWait);

  // State and wait-counter registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StRst;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state logic; the counter restarts on every transition.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StRst:   state_d = StFetch;
      StFetch: if (mem_done) state_d = StDecode;
      StDecode: begin
        unique case (opcode)
          OpRtype: begin
            if (funct == FnAdd || funct == FnSub || funct == FnAnd) state_d = StExecR;
            else                                                    state_d = StExc;
          end
          OpAddi:      state_d = StExecI;
          OpLw, OpSw:  state_d = StAddr;
          OpBeq:       state_d = StBranch;
          OpJ:         state_d = StJump;
          default:     state_d = StExc;
        endcase
      end
      StExecR: begin
        // Only the arithmetic ops trap on overflow; AND never does.
        if (overflow && (funct == FnAdd || funct == FnSub)) state_d = StExc;
        else                                                state_d = StWbR;
      end
      StWbR:   state_d = StFetch;
      StExecI: state_d = overflow ? StExc : StWbI;
      StWbI:   state_d = StFetch;
      StAddr:  state_d = (opcode == OpSw) ? StMemWr : StMemRd;
      StMemRd: if (mem_done) state_d = StWbL;
      StWbL:   state_d = StFetch;
      StMemWr: state_d = StFetch;
      StBranch: state_d = StFetch;
      StJump:  state_d = StFetch;
      // Two cycles: save EPC, then vector the PC.
      StExc:   if (cnt_q != 3'd0) state_d = StFetch;
      default: state_d = StRst;
    endcase
    cnt_d = (state_d != state_q) ? 3'd0 : cnt_q + 3'd1;
  end

  // Moore output decode; everything defaults to 0.
  always_comb begin
    alu_src_a     = 1'b0;
    alu_src_b     = 2'b00;
    alu_op        = AluIdle;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_source     = 2'b00;
    iord          = 1'b0;
    mem_write     = 1'b0;
    ir_write      = 1'b0;
    ab_load       = 1'b0;
    aluout_write  = 1'b0;
    mdr_write     = 1'b0;
    reg_write     = 1'b0;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    epc_write     = 1'b0;
    unique case (state_q)
      StFetch: begin
        alu_src_b = 2'b01;
        alu_op    = AluAdd;
        if (mem_done) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
      end
      StDecode: begin
        alu_src_b    = 2'b11;
        alu_op       = AluAdd;
        ab_load      = 1'b1;
        aluout_write = 1'b1;
      end
      StExecR: begin
        alu_src_a    = 1'b1;
        aluout_write = 1'b1;
        unique case (funct)
          FnSub:   alu_op = AluSub;
          FnAnd:   alu_op = AluAnd;
          default: alu_op = AluAdd;
        endcase
      end
      StWbR: begin
        reg_write = 1'b1;
        reg_dst   = 1'b1;
      end
      StExecI, StAddr: begin
        alu_src_a    = 1'b1;
        alu_src_b    = 2'b10;
        alu_op       = AluAdd;
        aluout_write = 1'b1;
      end
      StWbI: reg_write = 1'b1;
      StMemRd: begin
        iord      = 1'b1;
        mdr_write = mem_done;
      end
      StWbL: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
      end
      StMemWr: begin
        iord      = 1'b1;
        mem_write = 1'b1;
      end
      StBranch: begin
        alu_src_a     = 1'b1;
        alu_op        = AluSub;
        pc_write_cond = 1'b1;
        pc_source     = 2'b01;
      end
      StJump: begin
        pc_write  = 1'b1;
        pc_source = 2'b10;
      end
      StExc: begin
        if (cnt_q == 3'd0) begin
          // ALU computes PC-4 for EPC.
          alu_src_b = 2'b01;
          alu_op    = AluSub;
          epc_write = 1'b1;
        end else begin
          pc_write  = 1'b1;
          pc_source = EXC_VECTOR_SEL;
        end
      end
      default: ;
    endcase
  end

  assign state_o = state_q;

  // zero is consumed by the datapath through pc_write_cond.
  logic unused_zero;
  assign unused_zero = zero;

endmodule

// File: tb/tb_mc_control_fsm.sv
// Directed bench for mc_control_fsm (MEM_LATENCY=2). Each cycle the full
// output set is packed and compared to a hand-built expected vector.
module tb_mc_control_fsm;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode, funct;
  logic       zero, overflow;
  logic       alu_src_a, pc_write, pc_write_cond, iord, mem_write, ir_write;
  logic       ab_load, aluout_write, mdr_write, reg_write, reg_dst, mem_to_reg;
  logic       epc_write;
  logic [1:0] alu_src_b, pc_source;
  logic [2:0] alu_op;
  logic [3:0] state_o;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mc_control_fsm #(.MEM_LATENCY(2), .EXC_VECTOR_SEL(2'b11)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .funct(funct), .zero(zero),
    .overflow(overflow), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .alu_op(alu_op), .pc_write(pc_write), .pc_write_cond(pc_write_cond),
    .pc_source(pc_source), .iord(iord), .mem_write(mem_write), .ir_write(ir_write),
    .ab_load(ab_load), .aluout_write(aluout_write), .mdr_write(mdr_write),
    .reg_write(reg_write), .reg_dst(reg_dst), .mem_to_reg(mem_to_reg),
    .epc_write(epc_write), .state_o(state_o)
  );

  // Flag positions inside the 12-bit enable field.
  localparam logic [11:0] PCW  = 12'b1000_0000_0000;
  localparam logic [11:0] PCWC = 12'b0100_0000_0000;
  localparam logic [11:0] IORD = 12'b0010_0000_0000;
  localparam logic [11:0] MW   = 12'b0001_0000_0000;
  localparam logic [11:0] IRW  = 12'b0000_1000_0000;
  localparam logic [11:0] AB   = 12'b0000_0100_0000;
  localparam logic [11:0] AOW  = 12'b0000_0010_0000;
  localparam logic [11:0] MDRW = 12'b0000_0001_0000;
  localparam logic [11:0] RW   = 12'b0000_0000_1000;
  localparam logic [11:0] RD   = 12'b0000_0000_0100;
  localparam logic [11:0] M2R  = 12'b0000_0000_0010;
  localparam logic [11:0] EPC  = 12'b0000_0000_0001;
  localparam logic [11:0] NONE = 12'b0000_0000_0000;

  function automatic logic [23:0] v(input logic [3:0] st, input logic a, input logic [1:0] b,
                                    input logic [2:0] op, input logic [1:0] pcs,
                                    input logic [11:0] fl);
    return {st, a, b, op, pcs, fl};
  endfunction

  function automatic logic [23:0] obs();
    return {state_o, alu_src_a, alu_src_b, alu_op, pc_source,
            pc_write, pc_write_cond, iord, mem_write, ir_write, ab_load,
            aluout_write, mdr_write, reg_write, reg_dst, mem_to_reg, epc_write};
  endfunction

  task automatic check(input string tag, input logic [23:0] got, input logic [23:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Advance one clock and compare outputs just after the edge.
  task automatic step(input string tag, input logic [23:0] exp);
    @(posedge clk);
    #1;
    check(tag, obs(), exp);
  endtask

  // Three FETCH cycles (writes on the last) then DECODE.
  task automatic fetch_decode(input string tag);
    step({tag, ".f0"}, v(4'd1, 1'b0, 2'b01, 3'b001, 2'b00, NONE));
    step({tag, ".f1"}, v(4'd1, 1'b0, 2'b01, 3'b001, 2'b00, NONE));
    step({tag, ".f2"}, v(4'd1, 1'b0, 2'b01, 3'b001, 2'b00, IRW | PCW));
    step({tag, ".dec"}, v(4'd2, 1'b0, 2'b11, 3'b001, 2'b00, AB | AOW));
  endtask

  task automatic exc_seq(input string tag);
    step({tag, ".exc0"}, v(4'd13, 1'b0, 2'b01, 3'b010, 2'b00, EPC));
    step({tag, ".exc1"}, v(4'd13, 1'b0, 2'b00, 3'b000, 2'b11, PCW));
  endtask

  task automatic set_instr(input logic [5:0] op, input logic [5:0] fn, input logic z,
                           input logic ov);
    opcode = op; funct = fn; zero = z; overflow = ov;
  endtask

  initial begin
    reset = 1'b1;
    set_instr(6'h00, 6'h20, 1'b0, 1'b0);
    step("rst", v(4'd0, 1'b0, 2'b00, 3'b000, 2'b00, NONE));
    reset = 1'b0;

    // add, no overflow
    fetch_decode("add");
    step("add.exr", v(4'd3, 1'b1, 2'b00, 3'b001, 2'b00, AOW));
    step("add.wbr", v(4'd4, 1'b0, 2'b00, 3'b000, 2'b00, RW | RD));

    // sub
    set_instr(6'h00, 6'h22, 1'b0, 1'b0);
    fetch_decode("sub");
    step("sub.exr", v(4'd3, 1'b1, 2'b00, 3'b010, 2'b00, AOW));
    step("sub.wbr", v(4'd4, 1'b0, 2'b00, 3'b000, 2'b00, RW | RD));

    // and with overflow raised throughout: never traps
    set_instr(6'h00, 6'h24, 1'b0, 1'b1);
    fetch_decode("and");
    step("and.exr", v(4'd3, 1'b1, 2'b00, 3'b011, 2'b00, AOW));
    step("and.wbr", v(4'd4, 1'b0, 2'b00, 3'b000, 2'b00, RW | RD));

    // lw
    set_instr(6'h23, 6'h00, 1'b0, 1'b0);
    fetch_decode("lw");
    step("lw.addr", v(4'd7, 1'b1, 2'b10, 3'b001, 2'b00, AOW));
    step("lw.m0", v(4'd8, 1'b0, 2'b00, 3'b000, 2'b00, IORD));
    step("lw.m1", v(4'd8, 1'b0, 2'b00, 3'b000, 2'b00, IORD));
    step("lw.m2", v(4'd8, 1'b0, 2'b00, 3'b000, 2'b00, IORD | MDRW));
    step("lw.wbl", v(4'd9, 1'b0, 2'b00, 3'b000, 2'b00, RW | M2R));

    // sw
    set_instr(6'h2B, 6'h00, 1'b0, 1'b0);
    fetch_decode("sw");
    step("sw.addr", v(4'd7, 1'b1, 2'b10, 3'b001, 2'b00, AOW));
    step("sw.mw", v(4'd10, 1'b0, 2'b00, 3'b000, 2'b00, IORD | MW));

    // beq taken and not taken look identical to control
    set_instr(6'h04, 6'h00, 1'b1, 1'b0);
    fetch_decode("beq1");
    step("beq1.br", v(4'd11, 1'b1, 2'b00, 3'b010, 2'b01, PCWC));
    set_instr(6'h04, 6'h00, 1'b0, 1'b0);
    fetch_decode("beq0");
    step("beq0.br", v(4'd11, 1'b1, 2'b00, 3'b010, 2'b01, PCWC));

    // jump
    set_instr(6'h02, 6'h00, 1'b0, 1'b0);
    fetch_decode("j");
    step("j.jmp", v(4'd12, 1'b0, 2'b00, 3'b000, 2'b10, PCW));

    // addi without and with overflow
    set_instr(6'h08, 6'h00, 1'b0, 1'b0);
    fetch_decode("addi");
    step("addi.exi", v(4'd5, 1'b1, 2'b10, 3'b001, 2'b00, AOW));
    step("addi.wbi", v(4'd6, 1'b0, 2'b00, 3'b000, 2'b00, RW));
    set_instr(6'h08, 6'h00, 1'b0, 1'b1);
    fetch_decode("addiov");
    step("addiov.exi", v(4'd5, 1'b1, 2'b10, 3'b001, 2'b00, AOW));
    exc_seq("addiov");

    // illegal opcode and illegal funct
    set_instr(6'h3F, 6'h00, 1'b0, 1'b0);
    fetch_decode("ill");
    exc_seq("ill");
    set_instr(6'h00, 6'h25, 1'b0, 1'b0);
    fetch_decode("illfn");
    exc_seq("illfn");

    // add with overflow traps
    set_instr(6'h00, 6'h20, 1'b0, 1'b1);
    fetch_decode("addov");
    step("addov.exr", v(4'd3, 1'b1, 2'b00, 3'b001, 2'b00, AOW));
    exc_seq("addov");

    // reset during MEM_RD counter=1
    set_instr(6'h23, 6'h00, 1'b0, 1'b0);
    fetch_decode("lwr");
    step("lwr.addr", v(4'd7, 1'b1, 2'b10, 3'b001, 2'b00, AOW));
    step("lwr.m0", v(4'd8, 1'b0, 2'b00, 3'b000, 2'b00, IORD));
    step("lwr.m1", v(4'd8, 1'b0, 2'b00, 3'b000, 2'b00, IORD));
    reset = 1'b1;
    step("lwr.rst", v(4'd0, 1'b0, 2'b00, 3'b000, 2'b00, NONE));
    reset = 1'b0;
    fetch_decode("post");
    step("post.addr", v(4'd7, 1'b1, 2'b10, 3'b001, 2'b00, AOW));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
